// File: rtl/emulib_rammodel_sched.sv
// Timing scheduler for the RAM model. Queues address requests and completed
// write-data events, then releases one B response or one R burst at a time,
// in acceptance order, once the programmed latency has elapsed.
module emulib_rammodel_sched #(
    parameter int ID_WIDTH     = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int LAT_WIDTH    = 8,
    parameter int TS_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 areq_valid,
    input  logic                 areq_write,
    input  logic [ID_WIDTH-1:0]  areq_id,
    input  logic [7:0]           areq_len,
    input  logic                 wreq_valid,
    input  logic                 wreq_last,
    input  logic [LAT_WIDTH-1:0] cfg_rd_latency,
    input  logic [LAT_WIDTH-1:0] cfg_wr_latency,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [ID_WIDTH-1:0]  b_id,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [ID_WIDTH-1:0]  r_id,
    output logic                 r_last,
    output logic                 err_overflow,
    output logic                 err_wlast
);

    localparam int AW = $clog2(MAX_INFLIGHT);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(MAX_INFLIGHT);

    typedef enum logic [1:0] {IDLE, RBURST, BRESP} state_t;

    state_t                             state;
    logic [TS_WIDTH-1:0]                now;
    logic [7:0]                         beat;
    logic [7:0]                         beat_nx;

    // request queue storage and write-done timestamps
    logic [MAX_INFLIGHT-1:0]                rq_write;
    logic [MAX_INFLIGHT-1:0][ID_WIDTH-1:0]  rq_id;
    logic [MAX_INFLIGHT-1:0][7:0]           rq_len;
    logic [MAX_INFLIGHT-1:0][TS_WIDTH-1:0]  rq_due;
    logic [MAX_INFLIGHT-1:0][TS_WIDTH-1:0]  wq_ts;

    logic [AW:0] rq_wp, rq_rp, wq_wp, wq_rp, wr_cnt;
    logic [AW:0] rq_cnt, wq_cnt;

    logic                rq_full, rq_push, rq_pop, wq_push, wq_pop;
    logic                wlast_ev, r_fire, b_fire;
    logic                head_write;
    logic [ID_WIDTH-1:0] head_id;
    logic [7:0]          head_len;
    logic [TS_WIDTH-1:0] head_due, wq_head, rd_due, wr_due;
    logic                rd_elig, wr_elig;

    // Modular "time t has been reached": sign bit of the wrapped difference.
    function automatic logic reached(input logic [TS_WIDTH-1:0] t_now,
                                     input logic [TS_WIDTH-1:0] t);
        logic [TS_WIDTH-1:0] d;
        d = t_now - t;
        return ~d[TS_WIDTH-1];
    endfunction

    assign rq_cnt   = rq_wp - rq_rp;
    assign wq_cnt   = wq_wp - wq_rp;
    assign rq_full  = (rq_cnt == FULL_CNT);
    assign rq_push  = areq_valid && !rq_full;
    assign wlast_ev = wreq_valid && wreq_last;
    // A wlast only counts when some queued write is still waiting for its data.
    assign wq_push  = wlast_ev && (wr_cnt > wq_cnt);

    assign rd_due = now + TS_WIDTH'(cfg_rd_latency);
    assign wr_due = now + TS_WIDTH'(cfg_wr_latency);

    assign head_write = rq_write[rq_rp[AW-1:0]];
    assign head_id    = rq_id[rq_rp[AW-1:0]];
    assign head_len   = rq_len[rq_rp[AW-1:0]];
    assign head_due   = rq_due[rq_rp[AW-1:0]];
    assign wq_head    = wq_ts[wq_rp[AW-1:0]];

    assign rd_elig = (rq_cnt != '0) && !head_write && reached(now, head_due);
    assign wr_elig = (rq_cnt != '0) && head_write && (wq_cnt != '0) && reached(now, wq_head);

    assign r_fire  = r_valid && r_ready;
    assign b_fire  = b_valid && b_ready;
    assign rq_pop  = ((state == RBURST) && r_fire && r_last) || ((state == BRESP) && b_fire);
    assign wq_pop  = (state == BRESP) && b_fire;
    assign beat_nx = beat + 8'd1;

    // Queue payload storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (rq_push) begin
            rq_write[rq_wp[AW-1:0]] <= areq_write;
            rq_id[rq_wp[AW-1:0]]    <= areq_id;
            rq_len[rq_wp[AW-1:0]]   <= areq_len;
            rq_due[rq_wp[AW-1:0]]   <= rd_due;
        end
        if (wq_push)
            wq_ts[wq_wp[AW-1:0]] <= wr_due;
    end

    // Time base, queue pointers, pending-write count and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now          <= '0;
            rq_wp        <= '0;
            rq_rp        <= '0;
            wq_wp        <= '0;
            wq_rp        <= '0;
            wr_cnt       <= '0;
            err_overflow <= 1'b0;
            err_wlast    <= 1'b0;
        end else begin
            now <= now + 1'b1;
            if (rq_push) rq_wp <= rq_wp + 1'b1;
            if (rq_pop)  rq_rp <= rq_rp + 1'b1;
            if (wq_push) wq_wp <= wq_wp + 1'b1;
            if (wq_pop)  wq_rp <= wq_rp + 1'b1;
            wr_cnt <= wr_cnt + {{AW{1'b0}}, rq_push && areq_write} - {{AW{1'b0}}, wq_pop};
            if (areq_valid && rq_full) err_overflow <= 1'b1;
            if (wlast_ev && !wq_push)  err_wlast    <= 1'b1;
        end
    end

    // Completion FSM: one R burst or one B response at a time, outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_last  <= 1'b0;
            b_valid <= 1'b0;
            b_id    <= '0;
            beat    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_elig) begin
                        r_valid <= 1'b1;
                        r_id    <= head_id;
                        r_last  <= (head_len == 8'd0);
                        beat    <= '0;
                        state   <= RBURST;
                    end else if (wr_elig) begin
                        b_valid <= 1'b1;
                        b_id    <= head_id;
                        state   <= BRESP;
                    end
                end
                RBURST: begin
                    if (r_fire) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            beat    <= '0;
                            state   <= IDLE;
                        end else begin
                            beat   <= beat_nx;
                            r_last <= (beat_nx == head_len);
                        end
                    end
                end
                BRESP: begin
                    if (b_fire) begin
                        b_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_emulib_rammodel_sched.sv
// Bench for emulib_rammodel_sched: directed scenarios plus a randomized run
// checked against a per-transaction completion-time model.
module tb_emulib_rammodel_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       areq_valid, areq_write;
    logic [3:0] areq_id;
    logic [7:0] areq_len;
    logic       wreq_valid, wreq_last;
    logic [7:0] cfg_rd_latency, cfg_wr_latency;
    logic       b_valid, b_ready, r_valid, r_ready, r_last;
    logic [3:0] b_id, r_id;
    logic       err_overflow, err_wlast;

    int cyc    = 0;
    int checks = 0;
    int passes = 0;

    emulib_rammodel_sched #(.ID_WIDTH(4), .MAX_INFLIGHT(8), .LAT_WIDTH(8), .TS_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .areq_valid(areq_valid), .areq_write(areq_write), .areq_id(areq_id), .areq_len(areq_len),
        .wreq_valid(wreq_valid), .wreq_last(wreq_last),
        .cfg_rd_latency(cfg_rd_latency), .cfg_wr_latency(cfg_wr_latency),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_last(r_last),
        .err_overflow(err_overflow), .err_wlast(err_wlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic idle_inputs();
        areq_valid = 0; areq_write = 0; areq_id = 0; areq_len = 0;
        wreq_valid = 0; wreq_last = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        b_ready = 0; r_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        b_ready = 1; r_ready = 1;
        cfg_rd_latency = 0; cfg_wr_latency = 0;
        @(negedge clk);
        checks++;
        if ({b_valid, r_valid, r_last, b_id, r_id, err_overflow, err_wlast} !== 13'd0)
            $display("FAIL reset_outputs: got %b want 0", {b_valid, r_valid, r_last, b_id, r_id, err_overflow, err_wlast});
        else passes++;
        @(posedge clk); #1 rst_n = 1;
        repeat (4) @(negedge clk);
        checks++;
        if ({b_valid, r_valid, err_overflow, err_wlast} !== 4'd0)
            $display("FAIL reset_idle: got %b want 0", {b_valid, r_valid, err_overflow, err_wlast});
        else passes++;
    endtask

    task automatic test_read_single();
        int t0, first, nb;
        do_reset();
        cfg_rd_latency = 10; r_ready = 1;
        @(posedge clk); #1
        areq_valid = 1; areq_write = 0; areq_id = 3; areq_len = 0; t0 = cyc;
        @(posedge clk); #1 areq_valid = 0;
        first = -1; nb = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (r_valid) begin
                if (first < 0) first = cyc;
                nb++;
                checks++;
                if (r_id !== 4'd3 || r_last !== 1'b1)
                    $display("FAIL rd1_payload: got id=%0d last=%0d want id=3 last=1", r_id, r_last);
                else passes++;
            end
        end
        checks++;
        if (first != t0 + 11) $display("FAIL rd1_latency: got cycle %0d want %0d", first, t0 + 11);
        else passes++;
        checks++;
        if (nb != 1) $display("FAIL rd1_beats: got %0d want 1", nb);
        else passes++;
    endtask

    task automatic test_read_burst();
        int t0, first, beats, lasts;
        do_reset();
        cfg_rd_latency = 2;
        @(posedge clk); #1
        areq_valid = 1; areq_write = 0; areq_id = 5; areq_len = 3; t0 = cyc;
        first = -1; beats = 0; lasts = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1
            areq_valid = 0;
            r_ready = (i % 2 == 0);
            @(negedge clk);
            if (r_valid) begin
                if (first < 0) first = cyc;
                checks++;
                if (r_id !== 4'd5 || r_last !== (beats == 3))
                    $display("FAIL burst_beat: got id=%0d last=%0d want id=5 last=%0d (beat %0d)", r_id, r_last, beats == 3, beats);
                else passes++;
                if (r_ready) begin
                    beats++;
                    if (r_last) lasts++;
                end
            end
        end
        checks++;
        if (first != t0 + 3) $display("FAIL burst_latency: got cycle %0d want %0d", first, t0 + 3);
        else passes++;
        checks++;
        if (beats != 4 || lasts != 1) $display("FAIL burst_count: got beats=%0d lasts=%0d want 4/1", beats, lasts);
        else passes++;
    endtask

    task automatic test_long_burst();
        int beats, lasts, last_at;
        do_reset();
        cfg_rd_latency = 1; r_ready = 1;
        @(posedge clk); #1
        areq_valid = 1; areq_write = 0; areq_id = 9; areq_len = 8'd255;
        @(posedge clk); #1 areq_valid = 0;
        beats = 0; lasts = 0; last_at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (r_valid) begin
                beats++;
                if (r_last) begin lasts++; last_at = beats; end
            end
        end
        checks++;
        if (beats != 256 || lasts != 1 || last_at != 256)
            $display("FAIL len255: got beats=%0d lasts=%0d last_at=%0d want 256/1/256", beats, lasts, last_at);
        else passes++;
    endtask

    task automatic test_write();
        int t0, first, nb;
        do_reset();
        cfg_wr_latency = 5; b_ready = 1;
        @(posedge clk); #1
        areq_valid = 1; areq_write = 1; areq_id = 7; areq_len = 0; t0 = cyc;
        first = -1; nb = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1
            areq_valid = 0;
            wreq_valid = (cyc == t0 + 4);
            wreq_last  = (cyc == t0 + 4);
            @(negedge clk);
            if (b_valid) begin
                if (first < 0) first = cyc;
                nb++;
                checks++;
                if (b_id !== 4'd7) $display("FAIL wr_id: got %0d want 7", b_id);
                else passes++;
            end
        end
        checks++;
        if (first != t0 + 10) $display("FAIL wr_latency: got cycle %0d want %0d", first, t0 + 10);
        else passes++;
        checks++;
        if (nb != 1 || err_wlast !== 1'b0) $display("FAIL wr_count: got nb=%0d err_wlast=%0d want 1/0", nb, err_wlast);
        else passes++;
    endtask

    task automatic test_order();
        int t0, bfirst, rfirst;
        do_reset();
        cfg_rd_latency = 0; cfg_wr_latency = 0; b_ready = 1; r_ready = 1;
        @(posedge clk); #1
        areq_valid = 1; areq_write = 1; areq_id = 1; areq_len = 0; t0 = cyc;
        bfirst = -1; rfirst = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1
            areq_valid = (cyc == t0 + 1); areq_write = 0; areq_id = 2; areq_len = 0;
            wreq_valid = (cyc == t0 + 8); wreq_last = (cyc == t0 + 8);
            @(negedge clk);
            if (b_valid && bfirst < 0) begin
                bfirst = cyc;
                checks++;
                if (b_id !== 4'd1) $display("FAIL order_bid: got %0d want 1", b_id); else passes++;
            end
            if (r_valid && rfirst < 0) begin
                rfirst = cyc;
                checks++;
                if (r_id !== 4'd2) $display("FAIL order_rid: got %0d want 2", r_id); else passes++;
            end
        end
        checks++;
        if (bfirst != t0 + 10) $display("FAIL order_b_time: got %0d want %0d", bfirst, t0 + 10); else passes++;
        checks++;
        if (rfirst != t0 + 12) $display("FAIL order_r_time: got %0d want %0d", rfirst, t0 + 12); else passes++;
    endtask

    task automatic test_overflow();
        int nb;
        do_reset();
        cfg_rd_latency = 0; r_ready = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1
            areq_valid = 1; areq_write = 0; areq_id = 4'(k); areq_len = 0;
            @(negedge clk);
            if (k == 8) begin
                checks++;
                if (err_overflow !== 1'b0) $display("FAIL ovf_early: got %0d want 0", err_overflow); else passes++;
            end
        end
        @(posedge clk); #1 areq_valid = 0;
        @(negedge clk);
        checks++;
        if (err_overflow !== 1'b1) $display("FAIL ovf_flag: got %0d want 1", err_overflow); else passes++;
        r_ready = 1;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (r_valid && r_ready) begin
                checks++;
                if (r_id !== 4'(nb)) $display("FAIL ovf_id: got %0d want %0d", r_id, nb); else passes++;
                nb++;
            end
            @(negedge clk);
        end
        checks++;
        if (nb != 8) $display("FAIL ovf_count: got %0d want 8", nb); else passes++;
    endtask

    task automatic test_wlast_reset();
        bit seen;
        do_reset();
        @(posedge clk); #1 wreq_valid = 1; wreq_last = 1;
        @(posedge clk); #1 wreq_valid = 0; wreq_last = 0;
        @(negedge clk);
        checks++;
        if (err_wlast !== 1'b1 || err_overflow !== 1'b0)
            $display("FAIL wlast_flag: got wlast=%0d ovf=%0d want 1/0", err_wlast, err_overflow);
        else passes++;
        cfg_rd_latency = 0; r_ready = 1;
        @(posedge clk); #1
        areq_valid = 1; areq_write = 0; areq_id = 4; areq_len = 7;
        @(posedge clk); #1 areq_valid = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = r_valid;
        end
        checks++;
        if (!seen) $display("FAIL midburst_start: got r_valid=0 want 1 within 10 cycles"); else passes++;
        @(negedge clk);
        rst_n = 0;
        #1;
        checks++;
        if (r_valid !== 1'b0 || r_last !== 1'b0 || err_wlast !== 1'b0)
            $display("FAIL async_reset: got r_valid=%0d r_last=%0d err_wlast=%0d want 0", r_valid, r_last, err_wlast);
        else passes++;
        do_reset();
    endtask

    typedef struct {
        bit         wr;
        logic [3:0] id;
        logic [7:0] len;
        int         acc;
        int         lat;
        bit         wl_sent;
        int         wl;
        int         wlat;
    } txn_t;

    task automatic test_random();
        txn_t tx[0:127];
        txn_t t;
        int   wneed[$];
        int   n, hd, beat, prev_done, exp;
        bit   started, cur_v, oth_v, fire;
        n = 0; hd = 0; beat = 0; prev_done = -100; started = 0;
        do_reset();
        for (int i = 0; i < 4000 && !(i >= 1500 && hd == n); i++) begin
            @(posedge clk); #1
            idle_inputs();
            cfg_rd_latency = 8'($urandom_range(0, 12));
            cfg_wr_latency = 8'($urandom_range(0, 12));
            if (wneed.size() > 0 && tx[wneed[0]].acc < cyc && $urandom_range(0, 2) == 0) begin
                tx[wneed[0]].wl_sent = 1;
                tx[wneed[0]].wl      = cyc;
                tx[wneed[0]].wlat    = int'(cfg_wr_latency);
                void'(wneed.pop_front());
                wreq_valid = 1; wreq_last = 1;
            end else if ($urandom_range(0, 3) == 0) begin
                wreq_valid = 1;
            end
            if (i < 1500 && n < 100 && (n - hd) < 7 && $urandom_range(0, 2) == 0) begin
                tx[n].wr = 1'($urandom_range(0, 1));
                tx[n].id = 4'($urandom_range(0, 15));
                tx[n].len = tx[n].wr ? 8'd0 : 8'($urandom_range(0, 3));
                tx[n].acc = cyc;
                tx[n].lat = int'(cfg_rd_latency);
                tx[n].wl_sent = 0; tx[n].wl = 0; tx[n].wlat = 0;
                areq_valid = 1; areq_write = tx[n].wr; areq_id = tx[n].id; areq_len = tx[n].len;
                if (tx[n].wr) wneed.push_back(n);
                n++;
            end
            r_ready = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++;
            if (r_valid && b_valid) $display("FAIL rnd_exclusive: got b_valid=1 r_valid=1 want not both"); else passes++;
            if (hd < n) begin
                t = tx[hd];
                cur_v = t.wr ? b_valid : r_valid;
                oth_v = t.wr ? r_valid : b_valid;
                checks++;
                if (oth_v) $display("FAIL rnd_kind: got wrong channel valid for txn %0d (wr=%0d)", hd, t.wr); else passes++;
                if (started) begin
                    checks++;
                    if (!cur_v) $display("FAIL rnd_hold: got valid=0 want 1 for txn %0d", hd); else passes++;
                end else if (cur_v) begin
                    if (t.wr) exp = t.wl_sent ? t.wl + imax(2, t.wlat + 1) : -1;
                    else      exp = t.acc + imax(2, t.lat + 1);
                    exp = imax(exp, prev_done + 2);
                    checks++;
                    if (cyc != exp) $display("FAIL rnd_start: got cycle %0d want %0d for txn %0d", cyc, exp, hd); else passes++;
                    started = 1;
                end
                if (cur_v) begin
                    checks++;
                    if ((t.wr ? b_id : r_id) !== t.id)
                        $display("FAIL rnd_id: got %0d want %0d for txn %0d", t.wr ? b_id : r_id, t.id, hd);
                    else passes++;
                    if (!t.wr) begin
                        checks++;
                        if (r_last !== (beat == int'(t.len)))
                            $display("FAIL rnd_last: got %0d want %0d (beat %0d len %0d)", r_last, beat == int'(t.len), beat, t.len);
                        else passes++;
                    end
                    fire = t.wr ? b_ready : r_ready;
                    if (fire) begin
                        if (t.wr || beat == int'(t.len)) begin
                            hd++; prev_done = cyc; started = 0; beat = 0;
                        end else beat++;
                    end
                end
            end else begin
                checks++;
                if (r_valid || b_valid) $display("FAIL rnd_spurious: got r_valid=%0d b_valid=%0d want 0", r_valid, b_valid);
                else passes++;
            end
        end
        checks++;
        if (hd != n || n == 0) $display("FAIL rnd_drain: got %0d completed want %0d", hd, n); else passes++;
        checks++;
        if (err_overflow !== 1'b0 || err_wlast !== 1'b0)
            $display("FAIL rnd_errors: got ovf=%0d wlast=%0d want 0/0", err_overflow, err_wlast);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_read_single();
        test_read_burst();
        test_long_burst();
        test_write();
        test_order();
        test_overflow();
        test_wlast_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
